// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_pkg
// Description : Shared light codes, pedestrian FSM encoding and the
//               light-sequence legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

  // Upstream light encoding; 2'b11 never appears on a healthy controller
  typedef enum logic [1:0] {
    LT_RED = 2'b00,
    LT_YEL = 2'b01,
    LT_GRN = 2'b10,
    LT_BAD = 2'b11
  } light_t;

  // Pedestrian controller states
  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_WALK  = 2'd1,
    PS_CLEAR = 2'd2,
    PS_FAULT = 2'd3
  } ped_state_t;

  localparam logic [4:0] c_STALL_MAX = 5'd31;

  // Holding a light is always fine; otherwise only RED->GRN->YEL->RED
  function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
    logic ok;
    ok = 1'b0;
    if (cur == LT_BAD)                          ok = 1'b0;
    else if (cur == prev)                       ok = 1'b1;
    else if (prev == LT_RED && cur == LT_GRN)   ok = 1'b1;
    else if (prev == LT_GRN && cur == LT_YEL)   ok = 1'b1;
    else if (prev == LT_YEL && cur == LT_RED)   ok = 1'b1;
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_flasher.sv
`default_nettype none
// ============================================================================
// Module      : tlc_flasher
// Description : Flash phase generator; toggles every FLASH_DIV cycles,
//               restart forces the lamp-on phase and restarts the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_flasher #(
  parameter int FLASH_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase
);

  localparam logic [3:0] c_DIV_LAST = 4'(FLASH_DIV - 1);

  logic [3:0] r_div;
  logic       r_phase;

  // Divider and phase toggle; restart behaves like a local reset
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_div   <= 4'd0;
      r_phase <= 1'b1;
    end else if (r_div == c_DIV_LAST) begin
      r_div   <= 4'd0;
      r_phase <= ~r_phase;
    end else begin
      r_div   <= r_div + 4'd1;
    end
  end

  assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/tlc_ped_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlc_ped_ctrl
// Description : Pedestrian WALK / DON'T-WALK controller with clearance
//               countdown, plus a sticky safety monitor on the upstream
//               light sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_ped_ctrl
  import tlc_pkg::*;
#(
  parameter int WALK_CYC  = 3,
  parameter int CLR_CYC   = 2,
  parameter int FLASH_DIV = 1,
  parameter int TIMEOUT   = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tl_state,
  input  logic       ped_req,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] ped_cnt,
  output logic       ped_pend,
  output logic       fault
);

  localparam logic [3:0] c_WALK_LOAD = 4'(WALK_CYC - 1);
  localparam logic [3:0] c_CLR_LOAD  = 4'(CLR_CYC - 1);
  localparam logic [4:0] c_TIMEOUT   = 5'(TIMEOUT);

  ped_state_t r_state, w_state_nxt;
  logic [3:0] r_timer, w_timer_nxt;
  logic [1:0] r_prev;
  logic [4:0] r_stall, w_stall_nxt;
  logic       r_pend, w_pend_nxt;
  logic       r_walk, r_fault, r_flash_sel;
  logic [3:0] r_cnt;
  logic       w_red_entry, w_trip, w_restart, w_phase;

  // Stall counter: clears on any light change, otherwise counts and saturates
  always_comb begin
    w_stall_nxt = r_stall;
    if (tl_state != r_prev)          w_stall_nxt = 5'd0;
    else if (r_stall != c_STALL_MAX) w_stall_nxt = r_stall + 5'd1;
  end

  // Safety triggers and RED-entry detection against the previous light
  always_comb begin
    w_red_entry = (r_prev != LT_RED) && (tl_state == LT_RED);
    w_trip      = (tl_state == LT_BAD)
               || !legal_step(r_prev, tl_state)
               || (((r_state == PS_WALK) || (r_state == PS_CLEAR)) && (tl_state != LT_RED))
               || (w_stall_nxt >= c_TIMEOUT);
  end

  // Next-state logic; faults override the timers, timers override red_entry
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    if (r_state == PS_FAULT || w_trip) begin
      w_state_nxt = PS_FAULT;
      w_timer_nxt = 4'd0;
    end else begin
      case (r_state)
        PS_IDLE: begin
          if (w_red_entry && (r_pend || ped_req)) begin
            w_state_nxt = PS_WALK;
            w_timer_nxt = c_WALK_LOAD;
          end
        end
        PS_WALK: begin
          if (r_timer == 4'd0) begin
            w_state_nxt = PS_CLEAR;
            w_timer_nxt = c_CLR_LOAD;
          end else begin
            w_timer_nxt = r_timer - 4'd1;
          end
        end
        PS_CLEAR: begin
          if (r_timer == 4'd0) begin
            w_state_nxt = PS_IDLE;
            w_timer_nxt = 4'd0;
          end else begin
            w_timer_nxt = r_timer - 4'd1;
          end
        end
        default: w_state_nxt = PS_FAULT;
      endcase
    end
  end

  // Request latch (WALK entry serves it) and flash restart on CLEAR/FAULT entry
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_state_nxt == PS_WALK && r_state != PS_WALK) w_pend_nxt = 1'b0;
    else if (ped_req && r_state != PS_WALK)           w_pend_nxt = 1'b1;
    w_restart = ((w_state_nxt == PS_CLEAR) && (r_state != PS_CLEAR))
             || ((w_state_nxt == PS_FAULT) && (r_state != PS_FAULT));
  end

  // State, monitor history and registered lamp outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PS_IDLE;
      r_timer     <= 4'd0;
      r_prev      <= LT_RED;
      r_stall     <= 5'd0;
      r_pend      <= 1'b0;
      r_walk      <= 1'b0;
      r_cnt       <= 4'd0;
      r_fault     <= 1'b0;
      r_flash_sel <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_prev      <= tl_state;
      r_stall     <= w_stall_nxt;
      r_pend      <= w_pend_nxt;
      r_walk      <= (w_state_nxt == PS_WALK);
      r_cnt       <= (w_state_nxt == PS_CLEAR) ? (w_timer_nxt + 4'd1) : 4'd0;
      r_fault     <= (w_state_nxt == PS_FAULT);
      r_flash_sel <= (w_state_nxt == PS_CLEAR) || (w_state_nxt == PS_FAULT);
    end
  end

  tlc_flasher #(
    .FLASH_DIV (FLASH_DIV)
  ) u_flasher (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .phase   (w_phase)
  );

  // DON'T-WALK flashes in CLEAR/FAULT, otherwise it is the inverse of WALK
  assign dont_walk = r_flash_sel ? w_phase : ~r_walk;
  assign walk      = r_walk;
  assign ped_cnt   = r_cnt;
  assign ped_pend  = r_pend;
  assign fault     = r_fault;

endmodule
`default_nettype wire
